// File: rtl/powlib_pkg.sv
// Shared definitions for the powlib pipe primitives: stage-type selectors and
// a constant-evaluable clog2 used to size occupancy counters.
package powlib_pkg;

  localparam int POWLIB_STAGE_SKID = 1;
  localparam int POWLIB_STAGE_REG  = 0;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/powlib_flippipe_stage.sv
// One elastic stage of the flip pipe: either a 2-entry skid buffer with a
// registered ready, or a single register whose ready looks through downstream.
module powlib_flippipe_stage
  import powlib_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   INIT = '0,
  parameter int             EHB  = POWLIB_STAGE_SKID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] up_data,
  input  logic         up_vld,
  output logic         up_rdy,
  output logic [W-1:0] dn_data,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [1:0]   cnt
);

  if (EHB == POWLIB_STAGE_SKID) begin : g_skid
    logic [W-1:0] m;
    logic [W-1:0] s;
    logic         mv;
    logic         sv;
    logic         acc;
    logic         pop;

    // Ready depends only on the skid flag, so out_rdy never reaches in_rdy.
    assign up_rdy = !sv && !flush;
    assign acc    = up_vld && up_rdy;
    assign pop    = mv && dn_rdy && !flush;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbours' pre-edge values regardless of evaluation order.
    // NOTE: data registers are reset too, so out_data shows INIT after reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        m  <= INIT;
        s  <= INIT;
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (pop) begin
        if (sv) begin
          m  <= s;
          sv <= 1'b0;
        end else begin
          mv <= acc;
          if (acc) m <= up_data;
        end
      end else if (acc) begin
        if (mv) begin
          s  <= up_data;
          sv <= 1'b1;
        end else begin
          m  <= up_data;
          mv <= 1'b1;
        end
      end
    end

    assign dn_vld  = mv && !flush;
    assign dn_data = m;
    assign cnt     = {1'b0, mv} + {1'b0, sv};
  end else begin : g_reg
    logic [W-1:0] r;
    logic         rv;
    logic         acc;
    logic         pop;

    // A full register can still accept when its word leaves this same cycle.
    assign up_rdy = (!rv || dn_rdy) && !flush;
    assign acc    = up_vld && up_rdy;
    assign pop    = rv && dn_rdy && !flush;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r  <= INIT;
        rv <= 1'b0;
      end else if (flush) begin
        rv <= 1'b0;
      end else if (acc) begin
        r  <= up_data;
        rv <= 1'b1;
      end else if (pop) begin
        rv <= 1'b0;
      end
    end

    assign dn_vld  = rv && !flush;
    assign dn_data = r;
    assign cnt     = {1'b0, rv};
  end

endmodule

// File: rtl/powlib_flippipe.sv
// D-stage valid/ready register pipeline with synchronous flush and a live
// occupancy count; stage flavour selected by EHB.
module powlib_flippipe
  import powlib_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           D    = 2,
  parameter logic [W-1:0] INIT = '0,
  parameter int           EHB  = POWLIB_STAGE_SKID,
  localparam int          C    = (EHB == POWLIB_STAGE_SKID) ? 2 * D : D,
  localparam int          CW   = clog2(C + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [W-1:0]  in_data,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [CW-1:0] cnt
);

  for (genvar i = 0; i < D; i++) begin : g_stage
    logic [W-1:0]  up_data;
    logic          up_vld;
    logic          up_rdy;
    logic [W-1:0]  dn_data;
    logic          dn_vld;
    logic          dn_rdy;
    logic [1:0]    scnt;
    logic [CW-1:0] psum;

    // psum accumulates stage occupancies from the head towards the tail.
    if (i == 0) begin : g_head
      assign up_data = in_data;
      assign up_vld  = in_vld;
      assign psum    = CW'(scnt);
    end else begin : g_link
      assign up_data = g_stage[i-1].dn_data;
      assign up_vld  = g_stage[i-1].dn_vld;
      assign psum    = g_stage[i-1].psum + CW'(scnt);
    end

    if (i == D - 1) begin : g_tail
      assign dn_rdy = out_rdy;
    end else begin : g_mid
      assign dn_rdy = g_stage[i+1].up_rdy;
    end

    powlib_flippipe_stage #(
      .W    (W),
      .INIT (INIT),
      .EHB  (EHB)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_data (up_data),
      .up_vld  (up_vld),
      .up_rdy  (up_rdy),
      .dn_data (dn_data),
      .dn_vld  (dn_vld),
      .dn_rdy  (dn_rdy),
      .cnt     (scnt)
    );
  end

  assign in_rdy   = g_stage[0].up_rdy;
  assign out_vld  = g_stage[D-1].dn_vld;
  assign out_data = g_stage[D-1].dn_data;
  assign cnt      = g_stage[D-1].psum;

endmodule
